shift_seq8: RTL and testbench



---
 rtl/shift_seq8.sv | 117 +++++++++++
 tb/tb_shift_seq8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Shift command sequencer: splits a 0-7 bit shift into shifter steps of at most 3 bits.
// Optional abort port pair enabled by defining SHIFT_SEQ8_ABORT_EN.
module shift_seq8 (
    input  logic       clk,
    input  logic       reset_n,
`ifdef SHIFT_SEQ8_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    input  logic       start,
    input  logic [2:0] cmd,
    input  logic [2:0] amount,
    output logic       ready,
    output logic [2:0] op,
    output logic [1:0] shamt,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [2:0] cur_op;
    logic [2:0] rem;      // distance still owed after the step currently on op/shamt

    logic [2:0] f_op;
    logic [1:0] f_shamt;
    logic [2:0] f_rem;
    logic       f_err;
    logic [1:0] s_shamt;
    logic [2:0] s_rem;
    logic       accept;

    // First step of an incoming command; illegal ops and zero shifts collapse to one NOP step.
    always_comb begin
        f_op    = OP_NOP;
        f_shamt = 2'd0;
        f_rem   = 3'd0;
        f_err   = 1'b0;
        case (cmd)
            OP_LOAD: f_op = OP_LOAD;
            OP_LSL, OP_LSR, OP_ASR: begin
                if (amount != 3'd0) begin
                    f_op    = cmd;
                    f_shamt = (amount > 3'd3) ? 2'd3 : amount[1:0];
                    f_rem   = (amount > 3'd3) ? amount - 3'd3 : 3'd0;
                end
            end
            default: f_err = 1'b1;
        endcase
    end

    always_comb begin
        s_shamt = (rem > 3'd3) ? 2'd3 : rem[1:0];
        s_rem   = (rem > 3'd3) ? rem - 3'd3 : 3'd0;
    end

    assign ready  = (state == IDLE) || (rem == 3'd0);
    assign accept = start && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cur_op <= OP_NOP;
            rem    <= 3'd0;
            op     <= OP_NOP;
            shamt  <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef SHIFT_SEQ8_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef SHIFT_SEQ8_ABORT_EN
            aborted <= 1'b0;
            if (abort && state == RUN) begin
                state   <= IDLE;
                rem     <= 3'd0;
                op      <= OP_NOP;
                shamt   <= 2'd0;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else
`endif
            if (accept) begin
                state  <= RUN;
                cur_op <= f_op;
                op     <= f_op;
                shamt  <= f_shamt;
                rem    <= f_rem;
                busy   <= 1'b1;
                done   <= (f_rem == 3'd0);
                err    <= f_err;
            end else if (state == RUN && rem != 3'd0) begin
                op    <= cur_op;
                shamt <= s_shamt;
                rem   <= s_rem;
                done  <= (s_rem == 3'd0);
            end else begin
                state <= IDLE;
                rem   <= 3'd0;
                op    <= OP_NOP;
                shamt <= 2'd0;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8: directed spec scenarios plus random commands against a step-list model.
module tb_shift_seq8;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] cmd;
    logic [2:0] amount;
    logic       ready;
    logic [2:0] op;
    logic [1:0] shamt;
    logic       busy, done, err;
`ifdef SHIFT_SEQ8_ABORT_EN
    logic       abort, aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq8 dut (
        .clk(clk), .reset_n(reset_n),
`ifdef SHIFT_SEQ8_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .start(start), .cmd(cmd), .amount(amount),
        .ready(ready), .op(op), .shamt(shamt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Model: queue of steps still to be shown; front is the step presented this cycle.
    typedef struct {
        logic [2:0] op;
        logic [1:0] shamt;
        logic       err;
    } step_t;
    step_t q[$];

    localparam logic [8:0] IDLE_VEC = 9'b1_000_00_0_0_0;

    function automatic logic [8:0] obs_vec();
        return {ready, op, shamt, busy, done, err};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic last;
        if (q.size() == 0) return IDLE_VEC;
        last = (q.size() == 1);
        return {last, q[0].op, q[0].shamt, 1'b1, last, q[0].err};
    endfunction

    task automatic push_cmd(input logic [2:0] c, input logic [2:0] a);
        step_t s;
        int r;
        if (c == 3'b001) begin
            s.op = 3'b001; s.shamt = 2'd0; s.err = 1'b0; q.push_back(s);
        end else if (c >= 3'b010 && c <= 3'b100) begin
            if (a == 3'd0) begin
                s.op = 3'b000; s.shamt = 2'd0; s.err = 1'b0; q.push_back(s);
            end else begin
                r = int'(a);
                while (r > 0) begin
                    s.op = c; s.err = 1'b0;
                    s.shamt = (r > 3) ? 2'd3 : 2'(r);
                    q.push_back(s);
                    r -= int'(s.shamt);
                end
            end
        end else begin
            s.op = 3'b000; s.shamt = 2'd0; s.err = 1'b1; q.push_back(s);
        end
    endtask

    // Drive one cycle's inputs, step the model at the edge, return 1 time unit later.
    task automatic cycle(input logic s, input logic [2:0] c, input logic [2:0] a);
        logic m_rdy;
        start = s; cmd = c; amount = a;
        @(posedge clk);
        m_rdy = (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (s && m_rdy) push_cmd(c, a);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (obs_vec() !== IDLE_VEC) begin
            n_fail++; $display("FAIL reset_hold: got %b want %b", obs_vec(), IDLE_VEC);
        end
        #4 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 3'd0, 3'd0);
            n_tests++;
            if (obs_vec() !== IDLE_VEC) begin
                n_fail++; $display("FAIL reset_release[%0d]: got %b want %b", i, obs_vec(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_lsl7();
        logic [8:0] want [4] = '{9'b0_010_11_1_0_0, 9'b0_010_11_1_0_0, 9'b1_010_01_1_1_0, 9'b1_000_00_0_0_0};
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 3'b010, 3'd7);
            n_tests++;
            if (obs_vec() !== want[i]) begin
                n_fail++; $display("FAIL lsl7[%0d]: got %b want %b", i, obs_vec(), want[i]);
            end
        end
    endtask

    task automatic test_zero_load();
        logic [6:0] st [4] = '{{1'b1, 3'b100, 3'd0}, {1'b0, 3'b000, 3'd0}, {1'b1, 3'b001, 3'd6}, {1'b0, 3'b000, 3'd0}};
        for (int i = 0; i < 4; i++) begin
            cycle(st[i][6], st[i][5:3], st[i][2:0]);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL zero_load[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        // Second entry arrives during the first step and must be dropped.
        logic [6:0] st [5] = '{{1'b1, 3'b011, 3'd4}, {1'b1, 3'b100, 3'd7}, {1'b1, 3'b010, 3'd2}, {1'b0, 3'b000, 3'd0}, {1'b0, 3'b000, 3'd0}};
        logic [4:0] want [4] = '{{3'b011, 2'd3}, {3'b011, 2'd1}, {3'b010, 2'd2}, {3'b000, 2'd0}};
        for (int i = 0; i < 5; i++) begin
            cycle(st[i][6], st[i][5:3], st[i][2:0]);
            n_tests++;
            if (obs_vec() !== exp_vec() || (i < 4 && {op, shamt} !== want[i])) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] st [5] = '{{1'b1, 3'b111, 3'd5}, {1'b1, 3'b000, 3'd3}, {1'b1, 3'b101, 3'd0}, {1'b0, 3'b000, 3'd0}, {1'b0, 3'b000, 3'd0}};
        for (int i = 0; i < 5; i++) begin
            cycle(st[i][6], st[i][5:3], st[i][2:0]);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL illegal[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 3'b010, 3'd7);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== IDLE_VEC) begin
            n_fail++; $display("FAIL reset_mid: got %b want %b", obs_vec(), IDLE_VEC);
        end
        q.delete();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 3'd0, 3'd0);
            n_tests++;
            if (obs_vec() !== IDLE_VEC) begin
                n_fail++; $display("FAIL reset_mid_after[%0d]: got %b want %b", i, obs_vec(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef SHIFT_SEQ8_ABORT_EN
    task automatic test_abort();
        cycle(1'b1, 3'b010, 3'd7);
        abort = 1'b1;
        start = 1'b1; cmd = 3'b001; amount = 3'd0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        q.delete();
        n_tests++;
        if ({obs_vec(), aborted} !== {IDLE_VEC, 1'b1}) begin
            n_fail++; $display("FAIL abort: got %b/%b want %b/1", obs_vec(), aborted, IDLE_VEC);
        end
        cycle(1'b1, 3'b011, 3'd2);
        n_tests++;
        if ({obs_vec(), aborted} !== {exp_vec(), 1'b0}) begin
            n_fail++; $display("FAIL abort_next: got %b/%b want %b/0", obs_vec(), aborted, exp_vec());
        end
        cycle(1'b0, 3'd0, 3'd0);
    endtask
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; cmd = 3'd0; amount = 3'd0;
`ifdef SHIFT_SEQ8_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lsl7();
        test_zero_load();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
`ifdef SHIFT_SEQ8_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
